// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU core: instruction width, the opcode
// constants the sequencer needs to recognise, and the sequencer state enum.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INST_W = 8;

    // Opcodes live in the top five bits of the instruction byte.
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_MOVI = 5'd2;
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_CONST = 3'd1,
        ST_EXEC  = 3'd2,
        ST_IDLE  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    // Extract the opcode field from an instruction byte.
    function automatic logic [4:0] opcode_of(input logic [INST_W-1:0] ib);
        return ib[INST_W-1 -: 5];
    endfunction

endpackage

// File: rtl/inst_sequencer_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter: loadable, incrementing ADDR_W-bit register. Increment wraps
// modulo 2^ADDR_W with no carry flag. Load has priority over increment.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset, loads RESET_PC
//   load     in   load load_val this cycle
//   load_val in   ADDR_W value to load
//   inc      in   increment this cycle
//   pc       out  ADDR_W current counter value
// -----------------------------------------------------------------------------
module pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
// Fetch/execute sequencer for the 8-bit CPU core. Fetches one instruction byte
// (plus a trailing constant byte for move-const) from program memory over a
// request/ready handshake, holds it for the decoder and issues a one-cycle
// execute strobe that gates register writes.
//
// Optional feature macro: HALT_INST_EN
//   defined   -> opcode 11111 executes once, then the core parks in HALT
//   undefined -> 11111 is an ordinary opcode, halted is tied low
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   memAddr    out  ADDR_W read address (current pc)
//   memRd      out  read request, held until memRdy
//   memRdy     in   read complete, memData valid this cycle
//   memData    in   8  read data
//   stall      in   hold off the next fetch (sampled in EXEC/IDLE only)
//   inst       out  8  instruction register to the decoder
//   constData  out  8  constant operand of the last move-const
//   execEn     out  one-cycle execute strobe
//   pc         out  ADDR_W program counter
//   halted     out  core halted
// -----------------------------------------------------------------------------
module inst_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRd,
    input  logic              memRdy,
    input  logic [INST_W-1:0] memData,
    input  logic              stall,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] constData,
    output logic              execEn,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    seq_state_e        state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [INST_W-1:0] const_q, const_d;
    logic              pc_inc;
    logic              fetch_st;

    // No branch instructions yet, so the counter is never loaded.
    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ({ADDR_W{1'b0}}),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            inst_q  <= {OP_NOP, 3'b000};
            const_q <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            const_q <= const_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        const_d = const_q;
        pc_inc  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (memRdy) begin
                    inst_d  = memData;
                    pc_inc  = 1'b1;
                    state_d = (opcode_of(memData) == OP_MOVI) ? ST_CONST : ST_EXEC;
                end
            end
            ST_CONST: begin
                if (memRdy) begin
                    const_d = memData;
                    pc_inc  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef HALT_INST_EN
                if (opcode_of(inst_q) == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
`else
                if (stall) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
`endif
            end
            ST_IDLE: begin
                if (!stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign fetch_st = (state_q == ST_FETCH) || (state_q == ST_CONST);

    // The request is a state decode; gating with rst withdraws it the moment
    // reset asserts, since the state register already sits in FETCH then.
    assign memRd     = fetch_st && !rst;
    assign memAddr   = pc;
    assign inst      = inst_q;
    assign constData = const_q;
    assign execEn    = (state_q == ST_EXEC);

`ifdef HALT_INST_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
